// File: rtl/aes256_round_ctrl.sv
// AES-256 encrypt sequencer: load NB columns, ARK0 + NR rounds keyed per round, drain NB columns; 25-cycle minimum start-to-done.
// Stalls without timeout on in_full=0, key_ready=0 or out_full=1; optional abort input under AES_RCTRL_ABORT_EN.
module aes256_round_ctrl #(
  parameter int NR = 14,
  parameter int NB = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef AES_RCTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_full,
  output logic       in_rd_en,
  input  logic       key_ready,
  output logic       key_req,
  output logic [3:0] round_key_idx,
  output logic       en_ark,
  output logic       en_sub,
  output logic       en_shift,
  output logic       en_mix,
  output logic [1:0] col_idx,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARK0, S_ROUND, S_FINAL, S_DRAIN, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] round_nxt;
  logic [1:0] col_nxt;
  logic       kill;

`ifdef AES_RCTRL_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  assign round_key_idx = round;
  assign busy          = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      round   <= 4'd0;
      col_idx <= 2'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      round   <= round_nxt;
      col_idx <= col_nxt;
      done    <= (state_nxt == S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round;
    col_nxt   = col_idx;
    in_rd_en  = 1'b0;
    key_req   = 1'b0;
    en_ark    = 1'b0;
    en_sub    = 1'b0;
    en_shift  = 1'b0;
    en_mix    = 1'b0;
    out_wr_en = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_rd_en = in_full;
        if (in_full) begin
          if (col_idx == 2'(NB - 1)) begin
            col_nxt   = 2'd0;
            state_nxt = S_ARK0;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
      end
      S_ARK0: begin
        key_req = 1'b1;
        if (key_ready) begin
          en_ark    = 1'b1;
          round_nxt = 4'd1;
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        key_req = 1'b1;
        if (key_ready) begin
          en_sub    = 1'b1;
          en_shift  = 1'b1;
          en_mix    = 1'b1;
          en_ark    = 1'b1;
          round_nxt = round + 4'd1;
          if (round == 4'(NR - 1)) state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        // Last round skips MixColumns; round stays at NR through the drain.
        key_req = 1'b1;
        if (key_ready) begin
          en_sub    = 1'b1;
          en_shift  = 1'b1;
          en_ark    = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          if (col_idx == 2'(NB - 1)) begin
            col_nxt   = 2'd0;
            state_nxt = S_DONE;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
      end
      S_DONE: begin
        round_nxt = 4'd0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort wins over any step issued in the same cycle.
    if (kill) begin
      state_nxt = S_IDLE;
      round_nxt = 4'd0;
      col_nxt   = 2'd0;
      in_rd_en  = 1'b0;
      key_req   = 1'b0;
      en_ark    = 1'b0;
      en_sub    = 1'b0;
      en_shift  = 1'b0;
      en_mix    = 1'b0;
      out_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Directed bench for aes256_round_ctrl: nominal block, key/load/drain stalls, start-while-busy, reset and abort.
module tb_aes256_round_ctrl;
  localparam int NR = 14;

  logic       clk = 1'b0;
  logic       reset, start, in_full, key_ready, out_full;
  logic       in_rd_en, key_req, en_ark, en_sub, en_shift, en_mix, out_wr_en, busy, done;
  logic [3:0] round_key_idx, round;
  logic [1:0] col_idx;
`ifdef AES_RCTRL_ABORT_EN
  logic       abort;
`endif

  int checks = 0;
  int errors = 0;

  wire [7:0] strb = {in_rd_en, key_req, en_ark, en_sub, en_shift, en_mix, out_wr_en, done};

  aes256_round_ctrl #(.NR(NR), .NB(4)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef AES_RCTRL_ABORT_EN
    .abort(abort),
`endif
    .in_full(in_full), .in_rd_en(in_rd_en), .key_ready(key_ready), .key_req(key_req),
    .round_key_idx(round_key_idx), .en_ark(en_ark), .en_sub(en_sub), .en_shift(en_shift),
    .en_mix(en_mix), .col_idx(col_idx), .out_wr_en(out_wr_en), .out_full(out_full),
    .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_no_done(input string tag);
    int nd;
    nd = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (done) nd++;
    end
    chk(tag, nd, 0);
  endtask

  // kill_kind: 0 none, 1 reset, 2 abort; fires in the round==kill_round key cycle.
  task automatic run_block(input int stall_round, input int stall_len, input int in_gap,
                           input int out_gap, input int start_round, input int kill_kind,
                           input int kill_round, input int exp_lat);
    int n_rd, n_ark0, n_full, n_final, n_wr, cyc, exp_round;
    int stall_left, in_left, out_left;
    logic done_seen, pulsed;
    n_rd = 0; n_ark0 = 0; n_full = 0; n_final = 0; n_wr = 0;
    cyc = 1; exp_round = 1; done_seen = 1'b0; pulsed = 1'b0;
    stall_left = stall_len; in_left = in_gap; out_left = out_gap;

    start = 1'b1; in_full = 1'b1; key_ready = 1'b1; out_full = 1'b0;
    #1;
    chk("start_idle", {busy, strb}, 9'h0);
    tick();
    for (int k = 0; k < 200 && !done_seen; k++) begin
      cyc++;
      start = 1'b0; key_ready = 1'b1; in_full = 1'b1; out_full = 1'b0;
      if (key_req && round == 4'(stall_round) && stall_left > 0) begin
        key_ready = 1'b0; stall_left--;
      end
      if (n_rd == 2 && in_left > 0) begin
        in_full = 1'b0; in_left--;
      end
      if (n_final == 1 && n_wr == 2 && out_left > 0) begin
        out_full = 1'b1; out_left--;
      end
      if (!pulsed && start_round >= 0 && key_req && round == 4'(start_round)) begin
        start = 1'b1; pulsed = 1'b1;
      end
      #1;
      if (kill_kind == 1 && key_req && round == 4'(kill_round)) begin
        reset = 1'b1;
        #1;
        chk("rst_outputs", {busy, strb, round, col_idx, round_key_idx}, 0);
        tick();
        reset = 1'b0;
        idle_no_done("rst_no_done");
        return;
      end
`ifdef AES_RCTRL_ABORT_EN
      if (kill_kind == 2 && key_req && round == 4'(kill_round)) begin
        abort = 1'b1;
        #1;
        chk("abort_strb", strb, 8'h00);
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, round, col_idx}, 0);
        idle_no_done("abort_no_done");
        return;
      end
`endif
      chk("rd_wr_excl", in_rd_en & out_wr_en, 0);
      if (!in_full) chk("load_hold", {strb, col_idx}, {8'h00, 2'd2});
      if (out_full) chk("drain_hold", {strb, col_idx}, {8'h00, 2'd2});
      if (!key_ready) chk("key_stall", {strb, round}, {8'h40, 4'(stall_round)});
      if (in_rd_en) begin
        chk("rd_col", {strb, col_idx}, {8'h80, 2'(n_rd)});
        n_rd++;
      end
      if (en_ark && !en_sub) begin
        chk("ark0", {strb, round, round_key_idx}, {8'h60, 4'd0, 4'd0});
        n_ark0++;
      end
      if (en_mix) begin
        chk("round_step", {strb, round, round_key_idx}, {8'h7C, 4'(exp_round), 4'(exp_round)});
        exp_round++;
        n_full++;
      end
      if (en_sub && !en_mix) begin
        chk("final", {strb, round, round_key_idx}, {8'h78, 4'd14, 4'd14});
        n_final++;
      end
      if (out_wr_en) begin
        chk("wr_col", {strb, col_idx}, {8'h02, 2'(n_wr)});
        n_wr++;
      end
      if (done) begin
        done_seen = 1'b1;
        chk("latency", cyc, exp_lat);
        chk("done_cycle", {busy, strb}, 9'h001);
      end
      tick();
    end
    chk("done_seen", done_seen, 1);
    chk("counts", {8'(n_rd), 8'(n_ark0), 8'(n_full), 8'(n_final)}, {8'd4, 8'd1, 8'd13, 8'd1});
    chk("wr_count", n_wr, 4);
    chk("post_done", {busy, strb, round, col_idx}, 0);
    idle_no_done("extra_done");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_full = 1'b0; key_ready = 1'b0; out_full = 1'b0;
`ifdef AES_RCTRL_ABORT_EN
    abort = 1'b0;
`endif
    #1;
    chk("reset_state", {busy, strb, round, col_idx, round_key_idx}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_full = 1'b1; key_ready = 1'b1;
    tick();
    chk("idle_no_strobe", {busy, strb, round, col_idx}, 0);

    run_block(99, 0, 0, 0, -1, 0, 0, 25);  // nominal
    run_block(7,  3, 0, 0, -1, 0, 0, 28);  // key_ready low 3 cycles at round 7
    run_block(99, 0, 2, 2, -1, 0, 0, 29);  // load and drain back-pressure at column 2
    run_block(99, 0, 0, 0,  3, 0, 0, 25);  // start pulsed mid-block is ignored
    run_block(99, 0, 0, 0, -1, 1, 5, 0);   // reset at round 5
    run_block(99, 0, 0, 0, -1, 0, 0, 25);
`ifdef AES_RCTRL_ABORT_EN
    run_block(99, 0, 0, 0, -1, 2, 10, 0);  // abort at round 10
    run_block(99, 0, 0, 0, -1, 0, 0, 25);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
